pe_xbar_ctx_sched: RTL and testbench

Context scheduler that sequences the 8-bit switch word of one 4x4 PE crossbar (N/S/W/E, 32-bit lanes) cycle by cycle.
- Holds up to CTX_DEPTH routing contexts, each a switch word plus a repeat count.
- On start, plays the contexts 0..ctx_last in order, optionally looping, and drives the crossbar switch input from a register.
- Sits between the array configuration loader and each PE's crossbar.

---
 rtl/pe_xbar_ctx_sched.sv | 147 ++++++++++++++
 tb/tb_pe_xbar_ctx_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_xbar_ctx_sched.sv
// Context scheduler for one 4x4 PE crossbar: plays stored switch words with per-context
// repeat counts, optionally looping, and drives the crossbar select from a register.
module pe_xbar_ctx_sched #(
    parameter int unsigned CTX_DEPTH = 8,
    parameter int unsigned AW        = 3,
    parameter int unsigned RPT_W     = 4,
    parameter logic [7:0]  IDLE_SW   = 8'b00_01_10_11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [7:0]       cfg_switch,
    input  logic [RPT_W-1:0] cfg_rpt,
    input  logic [AW-1:0]    ctx_last,
    input  logic             loop_en,
    input  logic             start,
    input  logic             stop,
    output logic [7:0]       switch_out,
    output logic [AW-1:0]    cur_ctx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned SW_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [SW_W-1:0]  mem_sw_q  [CTX_DEPTH];
    logic [SW_W-1:0]  mem_sw_d  [CTX_DEPTH];
    logic [RPT_W-1:0] mem_rpt_q [CTX_DEPTH];
    logic [RPT_W-1:0] mem_rpt_d [CTX_DEPTH];
    logic [SW_W-1:0]  switch_q, switch_d;
    logic [AW-1:0]    cur_q, cur_d;
    logic [AW-1:0]    last_q, last_d;
    logic [RPT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load;
    logic [AW-1:0]    nxt_idx;

    // Context store; loads read the post-write view so a same-cycle write is seen first.
    always_comb begin
        mem_sw_d  = mem_sw_q;
        mem_rpt_d = mem_rpt_q;
        if (cfg_we) begin
            mem_sw_d[cfg_addr]  = cfg_switch;
            mem_rpt_d[cfg_addr] = cfg_rpt;
        end
    end

    always_comb begin
        state_d  = state_q;
        switch_d = switch_q;
        cur_d    = cur_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load     = 1'b0;
        nxt_idx  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                    last_d  = ctx_last;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d  = ST_IDLE;
                    switch_d = IDLE_SW;
                    busy_d   = 1'b0;
                    cur_d    = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - RPT_W'(1);
                end else if (cur_q != last_q) begin
                    load    = 1'b1;
                    nxt_idx = cur_q + AW'(1);
                end else if (loop_en) begin
                    load = 1'b1;
                end else begin
                    state_d  = ST_FIN;
                    switch_d = IDLE_SW;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    cur_d    = '0;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                switch_d = IDLE_SW;
                busy_d   = 1'b0;
                cur_d    = '0;
            end
        endcase

        if (load) begin
            switch_d = mem_sw_d[nxt_idx];
            cnt_d    = mem_rpt_d[nxt_idx];
            cur_d    = nxt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            switch_q <= IDLE_SW;
            cur_q    <= '0;
            last_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int unsigned i = 0; i < CTX_DEPTH; i++) begin
                mem_sw_q[i]  <= IDLE_SW;
                mem_rpt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            switch_q  <= switch_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mem_sw_q  <= mem_sw_d;
            mem_rpt_q <= mem_rpt_d;
        end
    end

    assign switch_out = switch_q;
    assign cur_ctx    = cur_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pe_xbar_ctx_sched.sv
// Bench for pe_xbar_ctx_sched: a cycle table, directed multi-cycle sequences, and random
// programs checked against an expanded expected-output list built from the stored contexts.
module tb_pe_xbar_ctx_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_switch;
    logic [3:0] cfg_rpt;
    logic [2:0] ctx_last;
    logic       loop_en;
    logic       start;
    logic       stop;
    logic [7:0] switch_out;
    logic [2:0] cur_ctx;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] m_sw  [8];
    logic [3:0] m_rpt [8];
    logic [7:0] esw[$];
    logic [2:0] ectx[$];

    typedef struct {
        bit         start;
        bit         stop;
        logic [7:0] sw;
        bit         busy;
        bit         done;
        logic [2:0] ctx;
    } vec_t;
    vec_t tbl[16];

    pe_xbar_ctx_sched dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_switch(cfg_switch), .cfg_rpt(cfg_rpt), .ctx_last(ctx_last),
        .loop_en(loop_en), .start(start), .stop(stop), .switch_out(switch_out),
        .cur_ctx(cur_ctx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_sw[i]  = 8'h1B;
            m_rpt[i] = 4'd0;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] s, input logic [3:0] r);
        cfg_we = 1'b1; cfg_addr = a; cfg_switch = s; cfg_rpt = r;
        m_sw[a] = s; m_rpt[a] = r;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Expected run: each context 0..last shown rpt+1 cycles, whole passes repeated while looping.
    task automatic build(input logic [2:0] last, input bit lp, input int minlen);
        esw.delete();
        ectx.delete();
        do begin
            for (int c = 0; c <= int'(last); c++)
                for (int h = 0; h <= int'(m_rpt[c]); h++) begin
                    esw.push_back(m_sw[c]);
                    ectx.push_back(3'(c));
                end
        end while (lp && esw.size() < minlen);
    endtask

    // Start a run and compare every RUN cycle; wr_k=-1 writes during the start cycle, -2 never.
    task automatic play(input int stop_k, input int wr_k, input logic [2:0] wa,
                        input logic [7:0] ws, input logic [3:0] wrp, input int clr_k);
        int n;
        start = 1'b1;
        if (wr_k == -1) begin
            cfg_we = 1'b1; cfg_addr = wa; cfg_switch = ws; cfg_rpt = wrp;
        end
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        n = (stop_k >= 0) ? stop_k + 1 : esw.size();
        for (int r = 0; r < n; r++) begin
            chk("run_sw", 32'(switch_out), 32'(esw[r]));
            chk("run_ctx", 32'(cur_ctx), 32'(ectx[r]));
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            if (r == wr_k) begin
                cfg_we = 1'b1; cfg_addr = wa; cfg_switch = ws; cfg_rpt = wrp;
            end
            if (r == clr_k) loop_en = 1'b0;
            if (r == stop_k) stop = 1'b1;
            @(negedge clk);
            stop   = 1'b0;
            cfg_we = 1'b0;
        end
        chk("end_sw", 32'(switch_out), 32'h1B);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_done", 32'(done), 32'(stop_k < 0));
        chk("end_ctx", 32'(cur_ctx), 32'd0);
        @(negedge clk);
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        bit lp;
        logic [2:0] last;

        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_switch = '0; cfg_rpt = '0;
        ctx_last = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_sw", 32'(switch_out), 32'h1B);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ctx", 32'(cur_ctx), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic program, start ignored in RUN and FIN, then start+stop in IDLE and a stop mid-hold.
        tbl[0]  = '{1'b1, 1'b0, 8'h1B, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0};
        tbl[2]  = '{1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 3'd1};
        tbl[3]  = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 3'd1};
        tbl[4]  = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 3'd1};
        tbl[5]  = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 3'd2};
        tbl[6]  = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 3'd2};
        tbl[7]  = '{1'b1, 1'b0, 8'h1B, 1'b0, 1'b1, 3'd0};
        tbl[8]  = '{1'b0, 1'b0, 8'h1B, 1'b0, 1'b0, 3'd0};
        tbl[9]  = '{1'b0, 1'b0, 8'h1B, 1'b0, 1'b0, 3'd0};
        tbl[10] = '{1'b1, 1'b1, 8'h1B, 1'b0, 1'b0, 3'd0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0};
        tbl[12] = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 3'd1};
        tbl[13] = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 3'd1};
        tbl[14] = '{1'b0, 1'b0, 8'h1B, 1'b0, 1'b0, 3'd0};
        tbl[15] = '{1'b0, 1'b0, 8'h1B, 1'b0, 1'b0, 3'd0};
        wr(3'd0, 8'h00, 4'd0);
        wr(3'd1, 8'h55, 4'd2);
        wr(3'd2, 8'hFF, 4'd1);
        ctx_last = 3'd2;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tbl%0d_sw", i), 32'(switch_out), 32'(tbl[i].sw));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("tbl%0d_ctx", i), 32'(cur_ctx), 32'(tbl[i].ctx));
            start = tbl[i].start;
            stop  = tbl[i].stop;
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
        end

        // Loop twice, clearing loop_en during the second pass's FF hold.
        loop_en = 1'b1;
        build(3'd2, 1'b1, 12);
        play(-1, -2, 3'd0, 8'h00, 4'd0, 10);
        loop_en = 1'b0;

        // Live write of ctx2 while ctx1 is held.
        m_sw[2] = 8'hA5; m_rpt[2] = 4'd0;
        build(3'd2, 1'b0, 0);
        play(-1, 1, 3'd2, 8'hA5, 4'd0, -1);

        // Write-first bypass of ctx0 in the start cycle.
        m_sw[0] = 8'h3C; m_rpt[0] = 4'd0;
        build(3'd2, 1'b0, 0);
        play(-1, -1, 3'd0, 8'h3C, 4'd0, -1);

        // Single-context program.
        ctx_last = 3'd0;
        build(3'd0, 1'b0, 0);
        play(-1, -2, 3'd0, 8'h00, 4'd0, -1);

        // Full depth at maximum repeat: 128 RUN cycles.
        for (int i = 0; i < 8; i++) wr(3'(i), 8'($urandom), 4'd15);
        ctx_last = 3'd7;
        build(3'd7, 1'b0, 0);
        chk("full_len", 32'(esw.size()), 32'd128);
        play(-1, -2, 3'd0, 8'h00, 4'd0, -1);

        // Random programs, some looping, some aborted by stop.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 8; i++) wr(3'(i), 8'($urandom), 4'($urandom_range(0, 4)));
            last = 3'($urandom_range(0, 7));
            lp   = 1'($urandom);
            ctx_last = last;
            loop_en  = lp;
            if (lp) begin
                k = $urandom_range(0, 60);
                build(last, 1'b1, k + 1);
            end else begin
                build(last, 1'b0, 0);
                k = ($urandom_range(0, 2) == 0) ? $urandom_range(0, esw.size() - 1) : -1;
            end
            play(k, -2, 3'd0, 8'h00, 4'd0, -1);
            loop_en = 1'b0;
        end

        // Asynchronous reset mid-run: outputs clear without a clock edge, contexts reset.
        ctx_last = 3'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sw", 32'(switch_out), 32'h1B);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_ctx", 32'(cur_ctx), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_nodone", 32'(done), 32'd0);
        ctx_last = 3'd0;
        build(3'd0, 1'b0, 0);
        play(-1, -2, 3'd0, 8'h00, 4'd0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
